// File: rtl/fir_pkg.sv
// Shared constants and helpers for the transposed-form FIR filter.
package fir_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_CW    = 8;
    localparam int DEFAULT_NTAPS = 8;

    // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int t;
        r = 0;
        t = v - 1;
        while (t > 0) begin
            r = r + 1;
            t = t >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-FIR tap: coefficient register, multiply, add, partial-sum register.
module fir_tap
    import fir_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int CW = DEFAULT_CW,
    parameter int OW = DEFAULT_DW + DEFAULT_CW + 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clear,
    input  logic          we,
    input  logic [CW-1:0] coef_in,
    input  logic [DW-1:0] x,
    input  logic [OW-1:0] sum_in,
    output logic [OW-1:0] sum_out
);

    logic [CW-1:0]    coef;
    logic [DW+CW-1:0] prod;
    logic [OW-1:0]    prod_ext;

    // Sign-extending both operands to the product width makes the low
    // DW+CW bits of an unsigned multiply equal the signed product.
    assign prod     = {{DW{coef[CW-1]}}, coef} * {{CW{x[DW-1]}}, x};
    assign prod_ext = {{(OW-DW-CW){prod[DW+CW-1]}}, prod};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coef <= '0;
        end else if (we) begin
            coef <= coef_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_out <= '0;
        end else if (clear) begin
            sum_out <= '0;
        end else if (en) begin
            sum_out <= prod_ext + sum_in;
        end
    end

endmodule

// File: rtl/fir_transposed.sv
// Transposed-form FIR filter with run-time writable coefficients and a sample strobe.
module fir_transposed
    import fir_pkg::*;
#(
    parameter int DW    = DEFAULT_DW,
    parameter int CW    = DEFAULT_CW,
    parameter int NTAPS = DEFAULT_NTAPS,
    parameter int OW    = DW + CW + clog2(NTAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [DW-1:0]             in_data,
    input  logic                      clear,
    input  logic                      coef_we,
    input  logic [clog2(NTAPS)-1:0]   coef_addr,
    input  logic [CW-1:0]             coef_data,
    output logic                      out_valid,
    output logic [OW-1:0]             out_data
);

    // sums[0] is the output register; sums[k] for k >= 1 is partial sum z[k-1].
    logic [OW-1:0] sums [NTAPS];
    logic          advance;

    assign advance  = in_valid & ~clear;
    assign out_data = sums[0];

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        logic tap_we;
        assign tap_we = coef_we && (int'(coef_addr) == k);

        if (k == NTAPS - 1) begin : g_last
            fir_tap #(.DW(DW), .CW(CW), .OW(OW)) u_tap (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (in_valid),
                .clear   (clear),
                .we      (tap_we),
                .coef_in (coef_data),
                .x       (in_data),
                .sum_in  ({OW{1'b0}}),
                .sum_out (sums[k])
            );
        end else begin : g_mid
            fir_tap #(.DW(DW), .CW(CW), .OW(OW)) u_tap (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (in_valid),
                .clear   (clear),
                .we      (tap_we),
                .coef_in (coef_data),
                .x       (in_data),
                .sum_in  (sums[k+1]),
                .sum_out (sums[k])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= advance;
        end
    end

endmodule

// File: tb/tb_fir_transposed.sv
// Self-checking bench for fir_transposed against a direct-form convolution model.
module tb_fir_transposed;

    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int NTAPS = 8;
    localparam int AW    = 3;
    localparam int OW    = 19;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 clear;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic [OW-1:0]        out_data;

    int checks;
    int failures;

    // Reference model: coefficient table and newest-first history of accepted samples.
    int b_m [NTAPS];
    int hist [$];
    int exp_data;

    fir_transposed #(.DW(DW), .CW(CW), .NTAPS(NTAPS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_y();
        int acc;
        acc = 0;
        for (int k = 0; k < hist.size(); k++) acc += b_m[k] * hist[k];
        return acc;
    endfunction

    // Drive one cycle; any pending coef write set by the caller takes effect on this edge.
    task automatic step(input logic v, input int d, input logic clr);
        in_valid = v;
        in_data  = DW'(d);
        clear    = clr;
        if (clr) begin
            hist.delete();
            exp_data = 0;
        end else if (v) begin
            hist.push_front(d);
            if (hist.size() > NTAPS) void'(hist.pop_back());
            exp_data = model_y();
        end
        if (coef_we) b_m[coef_addr] = int'(coef_data);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'sd17;
        clear    = 1'b0;
        coef_we  = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'sd9;
        hist.delete();
        exp_data = 0;
        for (int k = 0; k < NTAPS; k++) b_m[k] = 0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic load_coefs(input int c0, c1, c2, c3, c4, c5, c6, c7);
        int c [NTAPS];
        c = '{c0, c1, c2, c3, c4, c5, c6, c7};
        for (int k = 0; k < NTAPS; k++) begin
            coef_we   = 1'b1;
            coef_addr = AW'(k);
            coef_data = CW'(c[k]);
            step(1'b0, 0, 1'b0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%0b want=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%0d want=0", $signed(out_data));
        end
        // Coefficients are zero after reset (including the write attempted during reset).
        step(1'b1, 5, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_coefs got=%0b/%0d want=1/0", out_valid, $signed(out_data));
        end
    endtask

    task automatic test_impulse();
        int want [8];
        want = '{0, 1, 1, 0, 1, 1, 0, 0};
        load_coefs(0, 1, 1, 0, 1, 1, 0, 0);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i == 0) ? 1 : 0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || $signed(out_data) !== OW'(want[i])) begin
                failures++;
                $display("FAIL impulse[%0d] got=%0b/%0d want=1/%0d", i, out_valid, $signed(out_data), want[i]);
            end
        end
    endtask

    task automatic test_step();
        int want [10];
        want = '{1, 3, 6, 10, 15, 21, 28, 36, 36, 36};
        load_coefs(1, 2, 3, 4, 5, 6, 7, 8);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || $signed(out_data) !== OW'(want[i])) begin
                failures++;
                $display("FAIL step[%0d] got=%0b/%0d want=1/%0d", i, out_valid, $signed(out_data), want[i]);
            end
        end
    endtask

    task automatic test_gapped();
        int want [8];
        int held;
        want = '{1, 3, 6, 10, 15, 21, 28, 36};
        step(1'b0, 0, 1'b1);
        held = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 3 == 0) begin
                step(1'b1, 1, 1'b0);
                held = want[i / 3];
                checks++;
                if (out_valid !== 1'b1 || $signed(out_data) !== OW'(held)) begin
                    failures++;
                    $display("FAIL gapped_valid[%0d] got=%0b/%0d want=1/%0d", i, out_valid, $signed(out_data), held);
                end
            end else begin
                step(1'b0, 99, 1'b0);
                checks++;
                if (out_valid !== 1'b0 || $signed(out_data) !== OW'(held)) begin
                    failures++;
                    $display("FAIL gapped_idle[%0d] got=%0b/%0d want=0/%0d", i, out_valid, $signed(out_data), held);
                end
            end
        end
    endtask

    task automatic test_worst();
        load_coefs(-128, -128, -128, -128, -128, -128, -128, -128);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, -128, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || $signed(out_data) !== OW'(16384 * (i + 1))) begin
                failures++;
                $display("FAIL worst[%0d] got=%0d want=%0d", i, $signed(out_data), 16384 * (i + 1));
            end
        end
        checks++;
        if (out_data !== 19'sd131072) begin
            failures++;
            $display("FAIL worst_final got=%0d want=131072", $signed(out_data));
        end
    endtask

    task automatic test_coef_update();
        load_coefs(1, 2, 3, 4, 5, 6, 7, 8);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 1'b0);
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'sd5;
        step(1'b1, 1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== 19'sd10) begin
            failures++;
            $display("FAIL coef_same_cycle got=%0d want=10", $signed(out_data));
        end
        step(1'b1, 1, 1'b0);
        checks++;
        if ($signed(out_data) !== 19'sd19) begin
            failures++;
            $display("FAIL coef_next got=%0d want=19", $signed(out_data));
        end
    endtask

    task automatic test_clear();
        int want [3];
        want = '{1, 3, 6};
        load_coefs(1, 2, 3, 4, 5, 6, 7, 8);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1, 1'b0);
        step(1'b1, 1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL clear_out got=%0b/%0d want=0/0", out_valid, $signed(out_data));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || $signed(out_data) !== OW'(want[i])) begin
                failures++;
                $display("FAIL clear_restart[%0d] got=%0d want=%0d", i, $signed(out_data), want[i]);
            end
        end
        // Coefficient write performed while clear is asserted: b[1] becomes 10.
        coef_we   = 1'b1;
        coef_addr = 3'd1;
        coef_data = 8'sd10;
        step(1'b0, 0, 1'b1);
        step(1'b1, 1, 1'b0);
        step(1'b1, 1, 1'b0);
        checks++;
        if ($signed(out_data) !== 19'sd11) begin
            failures++;
            $display("FAIL clear_coef_write got=%0d want=11", $signed(out_data));
        end
    endtask

    task automatic test_reset_mid();
        load_coefs(1, 2, 3, 4, 5, 6, 7, 8);
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1, 1'b0);
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_mid_out got=%0b/%0d want=0/0", out_valid, $signed(out_data));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== '0) begin
                failures++;
                $display("FAIL reset_mid_zero[%0d] got=%0d want=0", i, $signed(out_data));
            end
        end
        do_reset();
        coef_we   = 1'b1;
        coef_addr = 3'd0;
        coef_data = 8'sd2;
        step(1'b0, 0, 1'b0);
        step(1'b1, 7, 1'b0);
        checks++;
        if ($signed(out_data) !== 19'sd14) begin
            failures++;
            $display("FAIL reset_first_sample got=%0d want=14", $signed(out_data));
        end
    endtask

    task automatic test_random();
        int held;
        load_coefs($signed(8'($urandom)), $signed(8'($urandom)), $signed(8'($urandom)),
                   $signed(8'($urandom)), $signed(8'($urandom)), $signed(8'($urandom)),
                   $signed(8'($urandom)), $signed(8'($urandom)));
        step(1'b0, 0, 1'b1);
        held = 0;
        for (int i = 0; i < 200; i++) begin
            logic v;
            int d;
            v = ($urandom_range(0, 2) != 0);
            d = $urandom_range(0, 255) - 128;
            step(v, d, 1'b0);
            if (v) held = exp_data;
            checks++;
            if (out_valid !== v || $signed(out_data) !== OW'(held)) begin
                failures++;
                $display("FAIL random[%0d] got=%0b/%0d want=%0b/%0d", i, out_valid, $signed(out_data), v, held);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        exp_data  = 0;
        for (int k = 0; k < NTAPS; k++) b_m[k] = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_impulse();
        test_step();
        test_gapped();
        test_worst();
        test_coef_update();
        test_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_transposed.md
FIR_TRANSPOSED -- requirements
Module: fir_transposed

Interface
REQ-001 SHALL have parameter DW, 8, signed input sample width in bits.
REQ-002 SHALL have parameter CW, 8, signed coefficient width in bits.
REQ-003 SHALL have parameter NTAPS, 8, tap count; legal values are 2 to 64.
REQ-004 SHALL have parameter OW, DW+CW+clog2(NTAPS), signed output width; it is derived and not overridden.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; one clock, synchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, sample strobe; the filter advances only when it is high.
REQ-008 SHALL have port in_data, input, DW, signed two's-complement sample.
REQ-009 SHALL have port clear, input, 1, synchronous flush of the delay line.
REQ-010 SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-011 SHALL have port coef_addr, input, clog2(NTAPS), tap index k of the coefficient being written.
REQ-012 SHALL have port coef_data, input, CW, signed coefficient value b[k].
REQ-013 SHALL have port out_valid, input-to-output registered, output, 1, result strobe.
REQ-014 SHALL have port out_data, output, OW, signed y[n].

Function
REQ-015 SHALL compute y[n] = sum over k=0..NTAPS-1 of b[k]*x[n-k], where n counts accepted samples only.
REQ-016 SHALL use the transposed structure with partial-sum registers z[0..NTAPS-2].
REQ-017 SHALL perform the following updates in each cycle where in_valid=1 and clear=0:
- out_data <= b[0]*x + z[0];
- z[k] <= b[k+1]*x + z[k+1];
- z[NTAPS-2] <= b[NTAPS-1]*x.
REQ-018 SHALL register out_valid <= in_valid & ~clear, giving a latency of exactly 1 cycle from the accepting edge to out_valid.
REQ-019 SHALL hold out_data and all z registers unchanged in cycles where in_valid=0; gaps in the input stream SHALL NOT alter results.
REQ-020 SHALL use full-precision signed arithmetic: products sign-extended to OW, no rounding, no saturation; OW guarantees no overflow.
REQ-021 SHALL write b[coef_addr] <= coef_data on the clock edge when coef_we=1.
REQ-022 SHALL ignore writes with coef_addr >= NTAPS.
REQ-023 SHALL, when coef_we and in_valid occur in the same cycle, compute that sample with the old coefficient; the new value applies from the next accepted sample.
REQ-024 SHALL, when clear=1, zero all z registers and out_data and drive out_valid=0 next cycle; coefficients are kept.
REQ-025 SHALL give clear priority over in_valid: a sample presented during clear is dropped.
REQ-026 SHALL allow coef_we during clear and perform the write.

Reset
REQ-027 SHALL, on rst_n=0 at a rising clk edge, zero all z, b[0..NTAPS-1] and out_data, and clear out_valid.
REQ-028 SHALL give reset priority over clear, in_valid and coef_we.
REQ-029 SHALL, after reset is asserted mid-stream, produce its first out_data equal to b[0]*x for the first accepted sample, with no residue from pre-reset samples.

Structure
REQ-030 SHALL take a clog2 helper function and default parameter constants from shared package fir_pkg.
REQ-031 SHALL implement each tap as one generated instance of sub-module fir_tap (coefficient register, multiply, add, partial-sum register with enable and clear).

Verification
REQ-032 Impulse test: coefficients 0,1,1,0,1,1,0,0; input 1 followed by seven 0s, continuous -> out_data 0,1,1,0,1,1,0,0, each one cycle after its input.
REQ-033 Step test: coefficients 1..8; continuous input 1 -> 1,3,6,10,15,21,28,36, then 36 steady.
REQ-034 Gapped-stream test: step test with in_valid pulsing every third cycle -> identical result sequence; out_valid only on cycles following in_valid.
REQ-035 Worst-case test: all coefficients -128, input -128 for 8 samples -> final output +131072, no wrap (OW=19).
REQ-036 Coefficient-update test: rewrite b[0] from 1 to 5 in the same cycle as a sample, with coefficients 1..8 and continuous input 1 -> that output uses 1; the next output rises by 4.
REQ-037 Clear/reset test: assert clear or rst_n mid-stream during the step test -> out_valid=0 next cycle; the restart sequence is 1,3,6,... after clear (coefficients kept) and all-zero output after reset (coefficients zeroed).
